// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer downstream of the UART receiver. Each completed frame
// (byte + parity-error flag) arrives on a one-cycle in_valid strobe and is
// stored in a first-word-fall-through FIFO. The host side drains the FIFO over
// a valid/ready interface. Overflow (frame dropped while full) and a
// saturating parity-error frame count are kept as statistics.
//
// Handshake: the head entry transfers on a rising clk edge where
// out_valid=1 and out_ready=1. out_valid never depends on out_ready, and
// out_ready is ignored while out_valid=0. The input side has no back-pressure:
// in_valid is a strobe, and a frame arriving while full without a
// same-cycle pop is dropped and flagged in overflow.
//
// Optional feature (macro UART_RX_DROP_PERR_EN): when defined, frames with a
// parity error are counted but never stored, never cause overflow, and
// out_perr is tied to 0. The default build (macro undefined) stores them.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid         frame-done strobe from the receiver
//   in_data/in_perr  received byte and its parity-error flag
//   out_valid/ready  head-entry handshake towards the host
//   out_data/perr    head entry contents (0 while empty)
//   level            number of stored entries, 0..DEPTH
//   full/empty       level==DEPTH / level==0
//   overflow         sticky dropped-frame flag
//   clr_ovf          clears overflow and perr_cnt
//   perr_cnt         saturating count of frames with in_perr=1
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_perr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [7:0]        perr_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  // Storage entry layout: {perr, data}
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        perr_cnt_q, perr_cnt_d;

  logic              drop_perr;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              ovf_evt;
  logic [DATA_W:0]   head;

  // Status is decoded straight from the level register, so there is no
  // combinational path from in_valid to any of these outputs.
  assign level     = level_q;
  assign full      = (level_q == DEPTH_L);
  assign empty     = (level_q == '0);
  assign out_valid = ~empty;
  assign overflow  = overflow_q;
  assign perr_cnt  = perr_cnt_q;

  // Head entry is masked while empty so stale storage contents left over
  // from before a reset are never visible.
  assign head     = empty ? '0 : mem_q[rd_ptr_q];
  assign out_data = head[DATA_W-1:0];

`ifdef UART_RX_DROP_PERR_EN
  assign drop_perr = in_perr;
  assign out_perr  = 1'b0;
`else
  assign drop_perr = 1'b0;
  assign out_perr  = head[DATA_W];
`endif

  assign pop      = out_valid & out_ready;
  assign push_req = in_valid & ~drop_perr;
  // A same-cycle pop frees the slot, so pushing while full is legal then.
  assign push     = push_req & (~full | pop);
  assign ovf_evt  = push_req & full & ~pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    perr_cnt_d = perr_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {in_perr, in_data};
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    if (push && !pop) begin
      level_d = level_q + (ADDR_W+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (ADDR_W+1)'(1);
    end

    // Clear is applied first so a same-cycle event wins over it.
    if (clr_ovf) begin
      overflow_d = 1'b0;
      perr_cnt_d = 8'd0;
    end
    if (ovf_evt) begin
      overflow_d = 1'b1;
    end
    if (in_valid && in_perr && (perr_cnt_d != 8'hFF)) begin
      perr_cnt_d = perr_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      perr_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
